// File: rtl/mac_sequencer.sv
// mac_sequencer: steps one neuron's input/weight memory index and accumulates
// the signed, saturating dot product of the selected elements, one MAC per clock.
// Optional build macro RELU_EN: clamps negative results to zero when done fires.
module mac_sequencer #(
  parameter int N     = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     base,
  input  logic [N-1:0]     len,
  output logic [N-1:0]     index,
  input  logic [7:0]       in_data,
  input  logic [7:0]       w_data,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result,
  output logic             sat
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [N-1:0]            index_q, index_d;
  logic [N-1:0]            count_q, count_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [15:0]             prod_q, prod_d;
  logic                    prod_v_q, prod_v_d;
  logic [ACC_W-1:0]        result_q, result_d;
  logic                    done_q, done_d;
  logic                    sat_q, sat_d;
  logic                    sat_acc_q, sat_acc_d;

  logic [15:0]             in_ext, w_ext, prod_new;
  logic [ACC_W:0]          acc_add;
  logic [ACC_W-1:0]        sum;

  // Adds a 16-bit product to the accumulator; returns {clamped, value}.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [15:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W-15){b[15]}}, b};
    if (s[ACC_W] != s[ACC_W-1]) begin
      if (s[ACC_W]) return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
      else          return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
    end
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  // Sign-extend operands so the multiply is a full signed 16-bit product.
  assign in_ext   = {{8{in_data[7]}}, in_data};
  assign w_ext    = {{8{w_data[7]}}, w_data};
  assign prod_new = in_ext * w_ext;
  assign acc_add  = sat_add(acc_q, prod_q);
  assign sum      = acc_add[ACC_W-1:0];

  // State register; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: a zero-length job never leaves IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && (len != '0)) state_d = S_RUN;
      S_RUN:   if (count_q == N'(1))     state_d = S_DRAIN;
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values; the product is pipelined one cycle before accumulation.
  always_comb begin
    index_d   = index_q;
    count_d   = count_q;
    acc_d     = acc_q;
    prod_d    = prod_q;
    prod_v_d  = prod_v_q;
    result_d  = result_q;
    done_d    = 1'b0;
    sat_d     = sat_q;
    sat_acc_d = sat_acc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            index_d   = base;
            count_d   = len;
            acc_d     = '0;
            sat_acc_d = 1'b0;
          end else begin
            result_d = '0;
            sat_d    = 1'b0;
            done_d   = 1'b1;
          end
        end
      end
      S_RUN: begin
        prod_d   = prod_new;
        prod_v_d = 1'b1;
        if (prod_v_q) begin
          acc_d     = sum;
          sat_acc_d = sat_acc_q | acc_add[ACC_W];
        end
        index_d = index_q + N'(1);
        count_d = count_q - N'(1);
      end
      S_DRAIN: begin
`ifdef RELU_EN
        result_d = sum[ACC_W-1] ? '0 : sum;
`else
        result_d = sum;
`endif
        done_d   = 1'b1;
        sat_d    = sat_acc_q | acc_add[ACC_W];
        prod_v_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q   <= '0;
      count_q   <= '0;
      acc_q     <= '0;
      prod_q    <= '0;
      prod_v_q  <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
      sat_acc_q <= 1'b0;
    end else begin
      index_q   <= index_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      prod_q    <= prod_d;
      prod_v_q  <= prod_v_d;
      result_q  <= result_d;
      done_q    <= done_d;
      sat_q     <= sat_d;
      sat_acc_q <= sat_acc_d;
    end
  end

  // Outputs: busy covers RUN and DRAIN, so it is already low in the done cycle.
  always_comb begin
    busy   = (state_q != S_IDLE);
    index  = index_q;
    done   = done_q;
    result = result_q;
    sat    = sat_q;
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: a stimulus process issues jobs and queues
// the expected {sat, result}; a monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base, len, index;
  logic [7:0]  in_data, w_data;
  logic        busy, done, sat;
  logic [23:0] result;

  logic [7:0]  in_mem [0:65535];
  logic [7:0]  w_mem  [0:65535];

  logic [24:0] exp_q[$];
  int          errs   = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign in_data = in_mem[index];
  assign w_data  = w_mem[index];

  mac_sequencer #(.N(16), .ACC_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
    .index(index), .in_data(in_data), .w_data(w_data), .busy(busy),
    .done(done), .result(result), .sat(sat)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    logic [24:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_done: got result %0d expected no done", $signed(result));
        end else begin
          e = exp_q.pop_front();
          chk("result", longint'($signed(result)), longint'($signed(e[23:0])));
          chk("sat", longint'(sat), longint'(e[24]));
        end
      end
    end
  end

  // Issues one job and checks index sequence, busy profile and done latency.
  // b2b: caller is already at the negedge of a done cycle; start there.
  // poke: pulse start with a different job while busy (must be ignored).
  task automatic run_job(input logic [15:0] b, input logic [15:0] l,
                         input logic [23:0] er, input logic es,
                         input bit b2b, input bit poke);
    int exp_lat;
    bit seen;
    logic [15:0] ei;
    exp_lat = (l == 0) ? 1 : int'(l) + 2;
    if (!b2b) @(negedge clk);
    start = 1'b1; base = b; len = l;
    exp_q.push_back({es, er});
    @(posedge clk); #1;
    start = 1'b0; base = 16'($urandom); len = 16'($urandom);
    seen = 1'b0;
    for (int c = 1; c <= int'(l) + 10 && !seen; c++) begin
      @(negedge clk);
      if (c <= int'(l)) begin
        ei = b + 16'(c - 1);
        chk("index", longint'(index), longint'(ei));
      end
      chk("busy", longint'(busy), longint'((l != 0) && (c <= int'(l) + 1)));
      if (done) begin
        chk("done_latency", c, exp_lat);
        seen = 1'b1;
      end
      if (poke && c == 1) begin
        start = 1'b1; base = 16'd7; len = 16'd2;
      end else begin
        start = 1'b0;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int dcnt;
    start = 1'b0; base = '0; len = '0;
    for (int i = 0; i < 65536; i++) begin
      in_mem[i] = 8'd0;
      w_mem[i]  = 8'd0;
    end
    rst_n = 1'b0;
    #3;
    chk("rst_busy",   longint'(busy),   0);
    chk("rst_done",   longint'(done),   0);
    chk("rst_result", longint'(result), 0);
    chk("rst_index",  longint'(index),  0);
    chk("rst_sat",    longint'(sat),    0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic dot product: 5+12+21+32 = 70
    for (int i = 0; i < 4; i++) begin
      in_mem[i] = 8'(i + 1);
      w_mem[i]  = 8'(i + 5);
    end
    run_job(16'd0, 16'd4, 24'd70, 1'b0, 1'b0, 1'b0);

    // Zero-length job: done in cycle 1, result 0, busy never high
    run_job(16'd0, 16'd0, 24'd0, 1'b0, 1'b0, 1'b0);

    // Index wraps past FFFF: 1+1+1 = 3
    in_mem[16'hFFFE] = 8'd1; w_mem[16'hFFFE] = 8'd1;
    in_mem[16'hFFFF] = 8'd1; w_mem[16'hFFFF] = 8'd1;
    in_mem[0]        = 8'd1; w_mem[0]        = 8'd1;
    run_job(16'hFFFE, 16'd3, 24'd3, 1'b0, 1'b0, 1'b0);

    // Reset mid-run aborts the job with no done afterwards
    for (int i = 300; i < 310; i++) begin
      in_mem[i] = 8'd3;
      w_mem[i]  = 8'd4;
    end
    @(negedge clk);
    start = 1'b1; base = 16'd300; len = 16'd10;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_before_reset", longint'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy",   longint'(busy),   0);
    chk("abort_done",   longint'(done),   0);
    chk("abort_result", longint'(result), 0);
    chk("abort_index",  longint'(index),  0);
    @(negedge clk); rst_n = 1'b1;
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("no_done_after_reset", dcnt, 0);

    // Saturation: 512 * 16384 = 8388608 clamps to 8388607
    for (int i = 0; i < 512; i++) begin
      in_mem[i] = 8'h80;
      w_mem[i]  = 8'h80;
    end
    run_job(16'd0, 16'd512, 24'd8388607, 1'b1, 1'b0, 1'b0);

    // Negative single product with a start poke while busy, then a
    // back-to-back job started in the done cycle (result 70 again)
    in_mem[100] = 8'hFF; w_mem[100] = 8'd5;
    for (int i = 0; i < 4; i++) begin
      in_mem[200 + i] = 8'(i + 1);
      w_mem[200 + i]  = 8'(i + 5);
    end
`ifdef RELU_EN
    run_job(16'd100, 16'd1, 24'd0, 1'b0, 1'b0, 1'b1);
`else
    run_job(16'd100, 16'd1, 24'hFFFFFB, 1'b0, 1'b0, 1'b1);
`endif
    run_job(16'd200, 16'd4, 24'd70, 1'b0, 1'b1, 1'b0);

    repeat (10) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // Watchdog: never hang
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "watchdog");
  end

endmodule
